adder_tree_core: RTL
====================

// Module: adder_tree_core
// PURPOSE
//  Pipelined, parameterised adder tree that consumes an operand vector from the S00_AXI register bank.
//  Produces the full-precision sum, read back through the same AXI4-Lite slave.
//  Streaming valid/ready on both sides; one vector per cycle throughput; global stall on backpressure.
//  Also provides a busy flag and a result counter for the status register.
// PARAMETERS
//  NUM_IN   8   operand count; power of two, 2..64
//  DATA_W   32  operand width (bits)
//  SIGNED   0   0: operands unsigned (zero-extend); 1: two's complement (sign-extend)
//  CNT_W    16  width of result_cnt
//  (derived) LEVELS = clog2(NUM_IN); SUM_W = DATA_W + LEVELS
// PORTS
//  ACLK       in   1              clock; all logic on rising edge
//  ARESET     in   1              synchronous, active-high reset
//  soft_clr   in   1              synchronous flush of pipeline and counter (register-bank pulse)
//  in_valid   in   1              operand vector valid
//  in_ready   out  1              core accepts vector this cycle
//  in_data    in   NUM_IN*DATA_W  operand k at [k*DATA_W +: DATA_W]
//  out_valid  out  1              out_sum valid
//  out_ready  in   1              consumer takes out_sum this cycle
//  out_sum    out  SUM_W          full-precision sum; never overflows
//  busy       out  1              any pipeline stage holds a valid vector
//  result_cnt out  CNT_W          number of results handed off (out_valid & out_ready); wraps
// BEHAVIOUR
//  Reset: all stage valids, out_valid, busy, result_cnt = 0; out_sum = 0.
//    in_ready = 1 from the first cycle after reset.
//  Pipeline: LEVELS register stages. Stage l adds pairs from stage l-1 at width DATA_W+l.
//    Stage 0 is in_data, extended per SIGNED.
//  Advance: adv = !out_valid | out_ready.
//    in_ready = adv (combinational).
//    All stages shift together when adv = 1; all hold when adv = 0.
//  Latency: a vector accepted at cycle t gives out_valid at t+LEVELS if no stall in between.
//    Each stall cycle adds 1 cycle.
//  Bubbles are not compressed: an invalid stage shifts as a bubble. Data regs may update on bubbles.
//  Ordering: results leave strictly in acceptance order. No loss or duplication under any out_ready pattern.
//  out_sum/out_valid hold stable while out_valid=1 & out_ready=0.
//  result_cnt increments on out_valid & out_ready and wraps 2^CNT_W-1 -> 0.
//  busy = OR of all stage valids (output stage included).
//  soft_clr: next cycle, all valids = 0 and result_cnt = 0; data regs are don't-care.
//    A vector presented with in_valid in the soft_clr cycle is dropped, even if in_ready=1.
//  ARESET has priority over soft_clr; both have priority over the handshake.
//  Reset or soft_clr mid-operation discards in-flight vectors; no partial result is emitted.
//  in_valid with in_ready=0: vector not taken; the source must hold it (AXI-stream rule).
// STRUCTURE
//  adder_tree_pkg: clog2 function, sum_width(DATA_W,NUM_IN) function, status bit positions
//    (BUSY_BIT=0) shared with the S00_AXI register map.
//  Sub-module adder_tree_level: one stage (N/2 pairwise adders, IN_W -> IN_W+1, valid reg, enable).
//    The core instantiates LEVELS of them in a generate loop plus the counter/handshake logic.
// TESTING
//  T1 unsigned: NUM_IN=8, operands 1..8, out_ready=1 -> out_sum=0x24 exactly 3 cycles after accept; result_cnt=1.
//  T2 width: all operands 0xFFFFFFFF, SIGNED=0 -> out_sum=35'h7_FFFF_FFF8.
//    Same vector with SIGNED=1 -> 35'h7_FFFF_FFF8 (-8).
//  T3 signed: all 0x80000000, SIGNED=1 -> 35'h4_0000_0000. Operands alternating 5/-5 -> 0.
//  T4 backpressure: stream 6 vectors (sums 0x24, 0x2C, ...), out_ready low for cycles 4..8 ->
//    in_ready low while stalled, 6 results in order, no loss or duplication, out_sum stable while stalled.
//  T5 flush: 3 vectors in flight, pulse soft_clr -> next cycle busy=0, out_valid=0, result_cnt=0.
//    No stale result appears afterwards. Repeat with ARESET mid-stream: same result.
//  T6 counter wrap: preload via 0xFFFF handoffs (or CNT_W=4 with 16 handoffs) -> one more handoff gives result_cnt=0.

Source files
------------

// File: rtl/adder_tree_pkg.sv
// Shared width helpers and status-register bit positions for the adder tree
// and the register bank that reads its status.
package adder_tree_pkg;

  localparam int BUSY_BIT = 0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int sum_width(input int data_w, input int num_in);
    return data_w + clog2(num_in);
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One adder-tree stage: N/2 pairwise adds, each growing the width by one bit; 1-cycle latency.
// Backpressure: the stage loads only when en is high and holds its contents otherwise.
module adder_tree_level #(
  parameter int N      = 2,
  parameter int IN_W   = 8,
  parameter int SIGNED = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  input  logic                        src_vld,
  input  logic [N*IN_W-1:0]           src_dat,
  output logic                        sum_vld,
  output logic [(N/2)*(IN_W+1)-1:0]   sum_dat
);

  localparam int OUT_W = IN_W + 1;
  localparam int PAIRS = N / 2;

  logic [PAIRS*OUT_W-1:0] sum_nxt;

  // One guard bit per level is enough to make the pair sum exact.
  function automatic logic [OUT_W-1:0] ext(input logic [IN_W-1:0] a);
    return (SIGNED != 0) ? {a[IN_W-1], a} : {1'b0, a};
  endfunction

  always_comb begin
    sum_nxt = '0;
    for (int k = 0; k < PAIRS; k++) begin
      sum_nxt[k*OUT_W +: OUT_W] = ext(src_dat[2*k*IN_W +: IN_W])
                                + ext(src_dat[(2*k+1)*IN_W +: IN_W]);
    end
  end

  // Data follows the enable even for bubbles; only the valid bit is flushed by clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_vld <= 1'b0;
      sum_dat <= '0;
    end else if (clr) begin
      sum_vld <= 1'b0;
    end else if (en) begin
      sum_vld <= src_vld;
      sum_dat <= sum_nxt;
    end
  end

endmodule

// File: rtl/adder_tree_core.sv
// Pipelined full-precision adder tree; clog2(NUM_IN) cycles latency, one vector per cycle.
// Backpressure: a single advance enable stalls every stage while an unaccepted result is held.
module adder_tree_core
  import adder_tree_pkg::*;
#(
  parameter int NUM_IN = 8,
  parameter int DATA_W = 32,
  parameter int SIGNED = 0,
  parameter int CNT_W  = 16
) (
  input  logic                                 ACLK,
  input  logic                                 ARESET,
  input  logic                                 soft_clr,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_IN*DATA_W-1:0]             in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [sum_width(DATA_W, NUM_IN)-1:0] out_sum,
  output logic                                 busy,
  output logic [CNT_W-1:0]                     result_cnt
);

  localparam int LEVELS = clog2(NUM_IN);

  logic              adv;
  logic [LEVELS-1:0] stage_vld;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int N_L = NUM_IN >> (l - 1);
    localparam int W_L = DATA_W + l - 1;

    logic [N_L*W_L-1:0]         lvl_in;
    logic                       lvl_in_vld;
    logic [(N_L/2)*(W_L+1)-1:0] lvl_out;
    logic                       lvl_out_vld;

    if (l == 1) begin : g_src
      assign lvl_in     = in_data;
      assign lvl_in_vld = in_valid;
    end else begin : g_src
      assign lvl_in     = g_lvl[l-1].lvl_out;
      assign lvl_in_vld = g_lvl[l-1].lvl_out_vld;
    end

    adder_tree_level #(
      .N      (N_L),
      .IN_W   (W_L),
      .SIGNED (SIGNED)
    ) u_level (
      .clk     (ACLK),
      .rst     (ARESET),
      .clr     (soft_clr),
      .en      (adv),
      .src_vld (lvl_in_vld),
      .src_dat (lvl_in),
      .sum_vld (lvl_out_vld),
      .sum_dat (lvl_out)
    );

    assign stage_vld[l-1] = lvl_out_vld;
  end

  assign out_valid = stage_vld[LEVELS-1];
  assign out_sum   = g_lvl[LEVELS].lvl_out;
  assign busy      = |stage_vld;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      result_cnt <= '0;
    end else if (soft_clr) begin
      result_cnt <= '0;
    end else if (out_valid && out_ready) begin
      result_cnt <= result_cnt + 1'b1;
    end
  end

endmodule
